// File: rtl/machine_csr_file.sv
//==============================================================================
// Module      : machine_csr_file
// Description : Machine-mode CSR file with Zicsr read/modify/write access,
//               trap-state updates (cause, EPC, MIE stacking), interrupt
//               pending sampling, 64-bit mcycle/minstret counters and the
//               trap vector.
//               Optional feature macro: MTVEC_VECTORED_EN (vectored mtvec).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module machine_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned HART_ID     = 0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] rs1_data_in,
    input  logic [4:0]  zimm_in,
    output logic [31:0] csr_data_out,
    output logic        illegal_csr_out,
    input  logic        set_cause_in,
    input  logic        i_or_e_in,
    input  logic [3:0]  cause_in,
    input  logic        set_epc_in,
    input  logic [31:0] pc_in,
    input  logic        misaligned_exception_in,
    input  logic [31:0] misaligned_addr_in,
    input  logic        mie_clear_in,
    input  logic        mie_set_in,
    input  logic        instruct_inc_in,
    input  logic        eirq_in,
    input  logic        tirq_in,
    input  logic        sirq_in,
    output logic        mie_out,
    output logic        meie_out,
    output logic        mtie_out,
    output logic        msie_out,
    output logic        meip_out,
    output logic        mtip_out,
    output logic        msip_out,
    output logic [31:0] epc_out,
    output logic [31:0] trap_address_out
);

    localparam logic [31:0] c_misa       = 32'h4000_0100;
    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

    // Architectural state
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_meie;
    logic        r_mie_mtie;
    logic        r_mie_msie;
    logic        r_mip_meip;
    logic        r_mip_mtip;
    logic        r_mip_msip;
    logic [31:0] r_mtvec_base;     // low two bits always zero
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;           // low two bits always zero
    logic        r_mcause_int;
    logic [3:0]  r_mcause_code;
    logic [31:0] r_mtval;
    logic [31:0] r_mcycle_lo;
    logic [31:0] r_mcycle_hi;
    logic [31:0] r_minstret_lo;
    logic [31:0] r_minstret_hi;

    logic [1:0]  w_mtvec_mode;
    logic [31:0] w_rd_data;
    logic        w_exists;
    logic        w_wants_write;
    logic        w_read_only;
    logic        w_illegal;
    logic        w_wr;
    logic [31:0] w_operand;
    logic [31:0] w_wr_data;
    logic [63:0] w_cycle_inc;
    logic [63:0] w_instret_inc;

    // Combinational read of the addressed CSR (pre-write value)
    always_comb begin
        w_rd_data = 32'h0;
        w_exists  = 1'b1;
        case (csr_addr_in)
            12'hF11, 12'hF12, 12'hF13: w_rd_data = 32'h0;
            12'hF14: w_rd_data = 32'(HART_ID);
            12'h301: w_rd_data = c_misa;
            12'h300: w_rd_data = {19'h0, 2'b11, 3'b000, r_mstatus_mpie,
                                  3'b000, r_mstatus_mie, 3'b000};
            12'h304: w_rd_data = {20'h0, r_mie_meie, 3'b000, r_mie_mtie,
                                  3'b000, r_mie_msie, 3'b000};
            12'h305: w_rd_data = r_mtvec_base | {30'h0, w_mtvec_mode};
            12'h340: w_rd_data = r_mscratch;
            12'h341: w_rd_data = r_mepc;
            12'h342: w_rd_data = {r_mcause_int, 27'h0, r_mcause_code};
            12'h343: w_rd_data = r_mtval;
            12'h344: w_rd_data = {20'h0, r_mip_meip, 3'b000, r_mip_mtip,
                                  3'b000, r_mip_msip, 3'b000};
            12'hB00, 12'hC00: w_rd_data = r_mcycle_lo;
            12'hB80, 12'hC80: w_rd_data = r_mcycle_hi;
            12'hB02, 12'hC02: w_rd_data = r_minstret_lo;
            12'hB82, 12'hC82: w_rd_data = r_minstret_hi;
            default: w_exists = 1'b0;
        endcase
    end

    // Set/clear with a zero rs1 field is a pure read
    assign w_wants_write = csr_wr_en_in &&
                           ((csr_op_in[1:0] == 2'b01) ||
                            ((csr_op_in[1:0] != 2'b00) && (zimm_in != 5'd0)));
    // Fxx and Cxx address blocks are read-only
    assign w_read_only   = (csr_addr_in[11:10] == 2'b11);
    assign w_illegal     = csr_wr_en_in && (!w_exists || (w_wants_write && w_read_only));
    assign w_wr          = w_wants_write && !w_illegal;
    assign w_operand     = csr_op_in[2] ? {27'h0, zimm_in} : rs1_data_in;

    // Read-modify-write data
    always_comb begin
        w_wr_data = w_operand;
        case (csr_op_in[1:0])
            2'b10:   w_wr_data = w_rd_data | w_operand;
            2'b11:   w_wr_data = w_rd_data & ~w_operand;
            default: w_wr_data = w_operand;
        endcase
    end

    assign illegal_csr_out = w_illegal;
    assign csr_data_out    = w_rd_data;

    // mstatus: trap entry/return stacking has priority over CSR writes
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (mie_clear_in) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mie_set_in) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr && csr_addr_in == 12'h300) begin
            r_mstatus_mie  <= w_wr_data[3];
            r_mstatus_mpie <= w_wr_data[7];
        end
    end

    // mie enables, mtvec base and mscratch: plain CSR writes
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_mie_meie   <= 1'b0;
            r_mie_mtie   <= 1'b0;
            r_mie_msie   <= 1'b0;
            r_mtvec_base <= MTVEC_RESET & c_align_mask;
            r_mscratch   <= 32'h0;
        end else if (w_wr) begin
            case (csr_addr_in)
                12'h304: begin
                    r_mie_meie <= w_wr_data[11];
                    r_mie_mtie <= w_wr_data[7];
                    r_mie_msie <= w_wr_data[3];
                end
                12'h305: r_mtvec_base <= w_wr_data & c_align_mask;
                12'h340: r_mscratch   <= w_wr_data;
                default: ;
            endcase
        end
    end

    // mip: one-cycle sample of the interrupt lines
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_mip_meip <= 1'b0;
            r_mip_mtip <= 1'b0;
            r_mip_msip <= 1'b0;
        end else begin
            r_mip_meip <= eirq_in;
            r_mip_mtip <= tirq_in;
            r_mip_msip <= sirq_in;
        end
    end

    // mepc: trap strobe wins over a CSR write in the same cycle
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_mepc <= 32'h0;
        end else if (set_epc_in) begin
            r_mepc <= pc_in & c_align_mask;
        end else if (w_wr && csr_addr_in == 12'h341) begin
            r_mepc <= w_wr_data & c_align_mask;
        end
    end

    // mcause/mtval: trap strobe wins over CSR writes in the same cycle
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_mcause_int  <= 1'b0;
            r_mcause_code <= 4'h0;
            r_mtval       <= 32'h0;
        end else if (set_cause_in) begin
            r_mcause_int  <= i_or_e_in;
            r_mcause_code <= cause_in;
            r_mtval       <= misaligned_exception_in ? misaligned_addr_in : 32'h0;
        end else if (w_wr && csr_addr_in == 12'h342) begin
            r_mcause_int  <= w_wr_data[31];
            r_mcause_code <= w_wr_data[3:0];
        end else if (w_wr && csr_addr_in == 12'h343) begin
            r_mtval       <= w_wr_data;
        end
    end

    assign w_cycle_inc   = {r_mcycle_hi, r_mcycle_lo} + 64'd1;
    assign w_instret_inc = {r_minstret_hi, r_minstret_lo} + {63'h0, instruct_inc_in};

    // mcycle: low-word write suppresses the increment; high-word write drops the carry
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_mcycle_lo <= 32'h0;
            r_mcycle_hi <= 32'h0;
        end else if (w_wr && csr_addr_in == 12'hB00) begin
            r_mcycle_lo <= w_wr_data;
        end else if (w_wr && csr_addr_in == 12'hB80) begin
            r_mcycle_hi <= w_wr_data;
            r_mcycle_lo <= w_cycle_inc[31:0];
        end else begin
            {r_mcycle_hi, r_mcycle_lo} <= w_cycle_inc;
        end
    end

    // minstret: same write rules as mcycle, counting retired instructions
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_minstret_lo <= 32'h0;
            r_minstret_hi <= 32'h0;
        end else if (w_wr && csr_addr_in == 12'hB02) begin
            r_minstret_lo <= w_wr_data;
        end else if (w_wr && csr_addr_in == 12'hB82) begin
            r_minstret_hi <= w_wr_data;
            r_minstret_lo <= w_instret_inc[31:0];
        end else begin
            {r_minstret_hi, r_minstret_lo} <= w_instret_inc;
        end
    end

`ifdef MTVEC_VECTORED_EN
    logic [1:0] r_mtvec_mode;

    // mtvec mode: only direct (00) and vectored (01) are accepted
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_mtvec_mode <= 2'b00;
        end else if (w_wr && csr_addr_in == 12'h305 && !w_wr_data[1]) begin
            r_mtvec_mode <= w_wr_data[1:0];
        end
    end

    assign w_mtvec_mode     = r_mtvec_mode;
    assign trap_address_out = r_mtvec_base +
                              (((r_mtvec_mode == 2'b01) && r_mcause_int) ?
                               {26'h0, r_mcause_code, 2'b00} : 32'h0);
`else
    assign w_mtvec_mode     = 2'b00;
    assign trap_address_out = r_mtvec_base;
`endif

    assign mie_out  = r_mstatus_mie;
    assign meie_out = r_mie_meie;
    assign mtie_out = r_mie_mtie;
    assign msie_out = r_mie_msie;
    assign meip_out = r_mip_meip;
    assign mtip_out = r_mip_mtip;
    assign msip_out = r_mip_msip;
    assign epc_out  = r_mepc;

endmodule

`default_nettype wire

// File: tb/tb_machine_csr_file.sv
//==============================================================================
// Module      : tb_machine_csr_file
// Description : Self-checking bench for machine_csr_file: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against a behavioural CSR model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_machine_csr_file;

    localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0403;
    localparam int unsigned TB_HART_ID     = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic        csr_wr_en;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] csr_data_out;
    logic        illegal_csr_out;
    logic        set_cause, i_or_e, set_epc, misaligned_exception;
    logic [3:0]  cause;
    logic [31:0] pc, misaligned_addr;
    logic        mie_clear, mie_set, instruct_inc, eirq, tirq, sirq;
    logic        mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out, msip_out;
    logic [31:0] epc_out, trap_address_out;

    always #5 clk = ~clk;

    machine_csr_file #(.MTVEC_RESET(TB_MTVEC_RESET), .HART_ID(TB_HART_ID)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .csr_addr_in(csr_addr), .csr_op_in(csr_op),
        .csr_wr_en_in(csr_wr_en), .rs1_data_in(rs1_data), .zimm_in(zimm),
        .csr_data_out(csr_data_out), .illegal_csr_out(illegal_csr_out),
        .set_cause_in(set_cause), .i_or_e_in(i_or_e), .cause_in(cause),
        .set_epc_in(set_epc), .pc_in(pc), .misaligned_exception_in(misaligned_exception),
        .misaligned_addr_in(misaligned_addr), .mie_clear_in(mie_clear), .mie_set_in(mie_set),
        .instruct_inc_in(instruct_inc), .eirq_in(eirq), .tirq_in(tirq), .sirq_in(sirq),
        .mie_out(mie_out), .meie_out(meie_out), .mtie_out(mtie_out), .msie_out(msie_out),
        .meip_out(meip_out), .mtip_out(mtip_out), .msip_out(msip_out),
        .epc_out(epc_out), .trap_address_out(trap_address_out)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    logic        m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // {exists, value} of a CSR in the model
    function automatic logic [32:0] mread(input logic [11:0] a);
        case (a)
            12'hF11, 12'hF12, 12'hF13: return {1'b1, 32'h0};
            12'hF14: return {1'b1, 32'(TB_HART_ID)};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h300: return {1'b1, 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0)};
            12'h304: return {1'b1, m_mie_reg};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, m_mip};
            12'hB00, 12'hC00: return {1'b1, m_cycle[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cycle[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_instret[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_instret[63:32]};
            default: return 33'h0;
        endcase
    endfunction

    function automatic logic exp_wants();
        return csr_wr_en && (csr_op[1:0] == 2'b01 || (csr_op[1:0] != 2'b00 && zimm != 5'd0));
    endfunction

    function automatic logic exp_illegal();
        logic [32:0] r;
        r = mread(csr_addr);
        return csr_wr_en && (!r[32] || (exp_wants() && csr_addr >= 12'hC00));
    endfunction

    function automatic logic [31:0] exp_trap();
        logic [31:0] t;
        t = m_mtvec & 32'hFFFF_FFFC;
`ifdef MTVEC_VECTORED_EN
        if (m_mtvec[1:0] == 2'b01 && m_mcause[31]) t = t + 32'(m_mcause[3:0]) * 4;
`endif
        return t;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mip = 0;
        m_mtvec = TB_MTVEC_RESET & 32'hFFFF_FFFC;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cycle = 0; m_instret = 0;
    endtask

    // Advance the model by one clock edge using the inputs applied this cycle
    task automatic model_clock();
        logic [32:0] r;
        logic [31:0] opnd, nv;
        logic        wr, o_mie, o_mpie;
        logic [63:0] nc, ni;
        if (!rst_n) begin
            model_reset();
            return;
        end
        r      = mread(csr_addr);
        wr     = exp_wants() && !exp_illegal();
        opnd   = csr_op[2] ? 32'(zimm) : rs1_data;
        nv     = (csr_op[1:0] == 2'b10) ? (r[31:0] | opnd) :
                 (csr_op[1:0] == 2'b11) ? (r[31:0] & ~opnd) : opnd;
        o_mie  = m_mie;
        o_mpie = m_mpie;
        nc     = m_cycle + 64'd1;
        ni     = m_instret + 64'(instruct_inc);
        if (wr) begin
            case (csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie_reg = nv & 32'h0000_0888;
                12'h305: begin
`ifdef MTVEC_VECTORED_EN
                    m_mtvec = (nv & 32'hFFFF_FFFC) | ((nv[1:0] <= 2'b01) ? 32'(nv[1:0]) : 32'(m_mtvec[1:0]));
`else
                    m_mtvec = nv & 32'hFFFF_FFFC;
`endif
                end
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause = nv & 32'h8000_000F;
                12'h343: m_mtval = nv;
                12'hB00: nc = {m_cycle[63:32], nv};
                12'hB80: nc = {nv, m_cycle[31:0] + 32'd1};
                12'hB02: ni = {m_instret[63:32], nv};
                12'hB82: ni = {nv, m_instret[31:0] + 32'(instruct_inc)};
                default: ;
            endcase
        end
        if (mie_clear) begin m_mpie = o_mie; m_mie = 1'b0; end
        else if (mie_set) begin m_mie = o_mpie; m_mpie = 1'b1; end
        if (set_epc) m_mepc = pc & 32'hFFFF_FFFC;
        if (set_cause) begin
            m_mcause = {i_or_e, 27'h0, cause};
            m_mtval  = misaligned_exception ? misaligned_addr : 32'h0;
        end
        m_mip     = (eirq ? 32'h800 : 32'h0) | (tirq ? 32'h80 : 32'h0) | (sirq ? 32'h8 : 32'h0);
        m_cycle   = nc;
        m_instret = ni;
    endtask

    task automatic compare_all();
        logic [32:0] r;
        r = mread(csr_addr);
        chk("csr_data", csr_data_out, r[31:0]);
        chk("illegal", 32'(illegal_csr_out), 32'(exp_illegal()));
        chk("mie_out", 32'(mie_out), 32'(m_mie));
        chk("mie_bits", {meie_out, mtie_out, msie_out}, {m_mie_reg[11], m_mie_reg[7], m_mie_reg[3]});
        chk("mip_bits", {meip_out, mtip_out, msip_out}, {m_mip[11], m_mip[7], m_mip[3]});
        chk("epc", epc_out, m_mepc);
        chk("trap_addr", trap_address_out, exp_trap());
    endtask

    // One clock: compare on the falling edge, update model on the rising edge
    task automatic do_cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1; csr_wr_en = 0; csr_op = 0; csr_addr = 12'h300; rs1_data = 0; zimm = 0;
        set_cause = 0; i_or_e = 0; cause = 0; set_epc = 0; pc = 0;
        misaligned_exception = 0; misaligned_addr = 0; mie_clear = 0; mie_set = 0;
        instruct_inc = 0; eirq = 0; tirq = 0; sirq = 0;
    endtask

    task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d, input logic [4:0] z);
        csr_wr_en = 1; csr_op = op; csr_addr = a; rs1_data = d; zimm = z;
    endtask

    task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_wr_en = 0; csr_addr = a;
        #1 chk(name, csr_data_out, exp);
        do_cycle();
    endtask

    logic [11:0] addr_list [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                   12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF11,
                                   12'hF12, 12'hF13, 12'hF14};

    task automatic random_inputs();
        rst_n     = ($urandom_range(0, 299) != 0);
        csr_wr_en = ($urandom_range(0, 9) < 7);
        csr_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_list[$urandom_range(0, 20)];
        csr_op    = 3'($urandom);
        rs1_data  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        zimm      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        set_cause = ($urandom_range(0, 7) == 0);
        i_or_e    = 1'($urandom);
        cause     = 4'($urandom);
        set_epc   = ($urandom_range(0, 7) == 0);
        pc        = $urandom;
        misaligned_exception = 1'($urandom);
        misaligned_addr      = $urandom;
        mie_clear    = ($urandom_range(0, 7) == 0);
        mie_set      = ($urandom_range(0, 7) == 0);
        instruct_inc = 1'($urandom);
        eirq = 1'($urandom); tirq = 1'($urandom); sirq = 1'($urandom);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        set_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        model_clock();
        #1;
        do_cycle();
        chk("rst_epc", epc_out, 32'h0);
        chk("rst_mie", 32'(mie_out), 32'h0);
        chk("rst_trap", trap_address_out, 32'h0000_0400);

        // Reset release
        rst_n = 1;
        do_cycle();
        peek("mcycle_first", 12'hB00, 32'h1);
        peek("mstatus_rst", 12'h300, 32'h0000_1800);
        peek("mtvec_rst", 12'h305, 32'h0000_0400);
        peek("mhartid", 12'hF14, 32'h5);
        peek("misa", 12'h301, 32'h4000_0100);

        // mscratch write then set
        csr(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd1);
        do_cycle();
        csr(3'b010, 12'h340, 32'h0000_00F0, 5'd2);
        #1 chk("csrrs_old", csr_data_out, 32'hDEAD_BEEF);
        do_cycle();
        peek("mscratch_final", 12'h340, 32'hDEAD_BEFF);

        // Trap entry and return
        csr(3'b001, 12'h300, 32'h8, 5'd1);
        do_cycle();
        set_idle();
        set_epc = 1; pc = 32'h104; set_cause = 1; cause = 4'd4;
        misaligned_exception = 1; misaligned_addr = 32'h203; mie_clear = 1;
        do_cycle();
        set_idle();
        peek("mepc_trap", 12'h341, 32'h104);
        peek("mcause_trap", 12'h342, 32'h4);
        peek("mtval_trap", 12'h343, 32'h203);
        peek("mstatus_trap", 12'h300, 32'h0000_1880);
        mie_set = 1;
        do_cycle();
        set_idle();
        peek("mstatus_mret", 12'h300, 32'h0000_1888);

        // mcycle wrap and read-only alias
        csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1);
        do_cycle();
        set_idle();
        do_cycle();
        peek("mcycle_wrap", 12'hB00, 32'h0);
        peek("mcycleh_carry", 12'hB80, 32'h1);
        csr(3'b001, 12'hC00, 32'h123, 5'd1);
        #1 chk("cycle_ro_illegal", 32'(illegal_csr_out), 32'h1);
        do_cycle();
        set_idle();
        peek("cycle_unchanged", 12'hC00, 32'h3);

        // mepc priority and alignment
        csr(3'b001, 12'h341, 32'h500, 5'd1);
        set_epc = 1; pc = 32'h200;
        do_cycle();
        set_idle();
        peek("mepc_prio", 12'h341, 32'h200);
        csr(3'b001, 12'h341, 32'h503, 5'd1);
        do_cycle();
        set_idle();
        peek("mepc_align", 12'h341, 32'h500);

        // Trap vector
        csr(3'b001, 12'h305, 32'h1001, 5'd1);
        set_cause = 1; i_or_e = 1; cause = 4'd7;
        do_cycle();
        set_idle();
`ifdef MTVEC_VECTORED_EN
        #1 chk("trap_vectored", trap_address_out, 32'h0000_101C);
        peek("mtvec_mode", 12'h305, 32'h0000_1001);
`else
        #1 chk("trap_direct", trap_address_out, 32'h0000_1000);
        peek("mtvec_mode", 12'h305, 32'h0000_1000);
`endif

        // Randomized traffic against the model
        repeat (4000) begin
            random_inputs();
            do_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
